// File: rtl/median_pkg.sv
// median_pkg: pixel/window constants and the Sn-to-bit-slice mapping shared with the median calc stage.
package median_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_SIZE = 9;
  localparam int WIN_PIXELS = WIN_SIZE * WIN_SIZE;
  localparam int WIN_W = PIX_W * WIN_PIXELS;
  localparam int SN_STRIDE = PIX_W;
  function automatic int sn_lsb(input int n);
    return SN_STRIDE * (n - 1);
  endfunction
endpackage

// File: rtl/median_line_buffer.sv
// median_line_buffer: one line of pixels, read-before-write at the current column.
module median_line_buffer
  import median_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         dout
);
  logic [PIX_W-1:0] mem_q [DEPTH];
  assign dout = mem_q[addr];
  always_ff @(posedge clk)
    if (we) mem_q[addr] <= din;
endmodule

// File: rtl/median_window_9x9_gen.sv
// median_window_9x9_gen: raster stream to 9x9 window generator for the median stage.
// Defining MEDIAN_WIN_FRAME_END_EN adds frame_end_o, marking the last window of a frame.
module median_window_9x9_gen
  import median_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done_i,
  input  logic [7:0]   data_i,
  output logic [647:0] window_o,
  output logic         done_o
`ifdef MEDIAN_WIN_FRAME_END_EN
  ,
  output logic         frame_end_o
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int ROW_W = PIX_W * WIN_SIZE;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WIN_W-1:0] sr_q, sr_d, win_q, win_d;
  logic done_q, done_d, last_col, last_row, hit;
  logic [PIX_W-1:0] tap [WIN_SIZE];
  // tap[k] is the pixel k lines above the incoming one, same column
  assign tap[0] = data_i;
  for (genvar g = 0; g < WIN_SIZE - 1; g++) begin : g_lb
    median_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
      .clk  (clk),
      .we   (done_i),
      .addr (col_q),
      .din  (tap[g]),
      .dout (tap[g+1])
    );
  end
  always_comb begin
    last_col = col_q == CW'(IMG_WIDTH - 1);
    last_row = row_q == RW'(IMG_HEIGHT - 1);
    hit = done_i && row_q >= RW'(WIN_SIZE - 1) && col_q >= CW'(WIN_SIZE - 1);
    col_d = done_i ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = (done_i && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
    sr_d = sr_q;
    for (int i = 0; i < WIN_SIZE; i++)
      if (done_i)
        sr_d[sn_lsb(i*WIN_SIZE+1) +: ROW_W] =
          {tap[WIN_SIZE-1-i], sr_q[sn_lsb(i*WIN_SIZE+2) +: ROW_W-PIX_W]};
    // window_o only loads on a produced window so it stays stable between pulses
    win_d = hit ? sr_d : win_q;
    done_d = hit;
  end
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      done_q <= done_d;
    end
  end
  assign window_o = win_q;
  assign done_o = done_q;
`ifdef MEDIAN_WIN_FRAME_END_EN
  logic fe_q, fe_d;
  always_comb fe_d = hit && last_col && last_row;
  always_ff @(posedge clk) fe_q <= rst ? 1'b0 : fe_d;
  assign frame_end_o = fe_q;
`endif
endmodule
